// File: rtl/dds_spi_pkg.sv
// Shared widths, FSM state codes and frame-length helper for the DDS serial-port responder.
package dds_spi_pkg;

  localparam int unsigned ADDR_W       = 5;
  localparam int unsigned DATA_W       = 64;
  localparam int unsigned INSTR_RW_BIT = 7;
  localparam int unsigned CNT_W        = 7;

  typedef logic [2:0] state_t;

  localparam state_t IDLE    = 3'd0;
  localparam state_t INSTR   = 3'd1;
  localparam state_t DATA_WR = 3'd2;
  localparam state_t DATA_RD = 3'd3;
  localparam state_t DONE    = 3'd4;

  // Data bytes following the instruction: 4 up to short_last, 8 above (incl. unimplemented).
  function automatic logic [3:0] nbytes(input logic [ADDR_W-1:0] addr,
                                        input int unsigned short_last);
    return (32'(addr) <= short_last) ? 4'd4 : 4'd8;
  endfunction

endpackage

// File: rtl/dds_spi_sync.sv
// Multi-flop synchronizer with registered rise/fall strobes aligned to the synchronized level.
module dds_spi_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;

  // Strobes are computed from the last two stages so they assert together with the new q.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chain <= '0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
      rise  <= chain[STAGES-2] & ~chain[STAGES-1];
      fall  <= ~chain[STAGES-2] & chain[STAGES-1];
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/dds_spi_slave.sv
// Device-side DDS serial-port responder: instruction decode, shadow/active banks, IO_UPDATE transfer.
module dds_spi_slave
  import dds_spi_pkg::*;
#(
  parameter int unsigned NREG        = 23,
  parameter int unsigned SHORT_LAST  = 10,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SCLK,
  input  logic              CS,
  input  logic              SDIO,
  output logic              SDO,
  input  logic              IO_UPDATE,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              wr_strobe,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              upd_pulse
);

  logic sclk_q, sclk_rise, sclk_fall;
  logic cs_q, cs_rise, cs_fall;
  logic sdio_q, sdio_rise, sdio_fall;
  logic upd_q, upd_rise, upd_fall;
  logic unused_sync;

  dds_spi_sync #(.STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(clk), .rst(rst), .d(SCLK), .q(sclk_q), .rise(sclk_rise), .fall(sclk_fall));
  dds_spi_sync #(.STAGES(SYNC_STAGES)) u_sync_cs (
    .clk(clk), .rst(rst), .d(CS), .q(cs_q), .rise(cs_rise), .fall(cs_fall));
  dds_spi_sync #(.STAGES(SYNC_STAGES)) u_sync_sdio (
    .clk(clk), .rst(rst), .d(SDIO), .q(sdio_q), .rise(sdio_rise), .fall(sdio_fall));
  dds_spi_sync #(.STAGES(SYNC_STAGES)) u_sync_upd (
    .clk(clk), .rst(rst), .d(IO_UPDATE), .q(upd_q), .rise(upd_rise), .fall(upd_fall));

  assign unused_sync = ^{sclk_q, cs_rise, sdio_rise, sdio_fall, upd_q, upd_fall};

  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return 32'(a) < NREG;
  endfunction

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]   shift_in_q, shift_in_d;
  logic [DATA_W-1:0]   shift_out_q, shift_out_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                commit_q, commit_d;
  logic                sdo_d;
  logic [7:0]          instr_c;
  logic [DATA_W-1:0]   rd_word_c;
  logic [CNT_W-1:0]    nbits_c;

  logic [DATA_W-1:0]   shadow_q [NREG];
  logic [DATA_W-1:0]   active_q [NREG];

  assign nbits_c = {nbytes(addr_q, SHORT_LAST), 3'b000};

  // Next-state and datapath control; CS high outside IDLE aborts the frame.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_in_d  = shift_in_q;
    shift_out_d = shift_out_q;
    addr_d      = addr_q;
    commit_d    = 1'b0;
    sdo_d       = SDO;
    instr_c     = {shift_in_q[6:0], sdio_q};
    rd_word_c   = '0;
    if (addr_ok(instr_c[ADDR_W-1:0])) rd_word_c = active_q[instr_c[ADDR_W-1:0]];

    if (state_q != IDLE && cs_q) begin
      state_d   = IDLE;
      sdo_d     = 1'b0;
      bit_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          sdo_d     = 1'b0;
          bit_cnt_d = '0;
          if (cs_fall) state_d = INSTR;
        end
        INSTR: begin
          if (sclk_rise) begin
            shift_in_d = {shift_in_q[DATA_W-2:0], sdio_q};
            bit_cnt_d  = bit_cnt_q + CNT_W'(1);
            if (bit_cnt_q == CNT_W'(7)) begin
              addr_d    = instr_c[ADDR_W-1:0];
              bit_cnt_d = '0;
              if (instr_c[INSTR_RW_BIT]) begin
                state_d = DATA_RD;
                // 32-bit registers are left-aligned so the shifter always emits from bit 63.
                shift_out_d = (nbytes(instr_c[ADDR_W-1:0], SHORT_LAST) == 4'd4) ?
                              {rd_word_c[31:0], 32'h0} : rd_word_c;
              end else begin
                state_d = DATA_WR;
              end
            end
          end
        end
        DATA_WR: begin
          if (sclk_rise) begin
            shift_in_d = {shift_in_q[DATA_W-2:0], sdio_q};
            bit_cnt_d  = bit_cnt_q + CNT_W'(1);
            if (bit_cnt_q == nbits_c - CNT_W'(1)) begin
              state_d  = DONE;
              commit_d = addr_ok(addr_q);
            end
          end
        end
        DATA_RD: begin
          if (sclk_fall) begin
            if (bit_cnt_q == nbits_c) begin
              sdo_d   = 1'b0;
              state_d = DONE;
            end else begin
              sdo_d       = shift_out_q[DATA_W-1];
              shift_out_d = {shift_out_q[DATA_W-2:0], 1'b0};
              bit_cnt_d   = bit_cnt_q + CNT_W'(1);
            end
          end
        end
        DONE: ;
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM, shifters and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_in_q  <= '0;
      shift_out_q <= '0;
      addr_q      <= '0;
      commit_q    <= 1'b0;
      SDO         <= 1'b0;
      wr_strobe   <= 1'b0;
      wr_addr     <= '0;
      upd_pulse   <= 1'b0;
      rd_data     <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_in_q  <= shift_in_d;
      shift_out_q <= shift_out_d;
      addr_q      <= addr_d;
      commit_q    <= commit_d;
      SDO         <= sdo_d;
      wr_strobe   <= commit_q;
      if (commit_q) wr_addr <= addr_q;
      upd_pulse   <= upd_rise;
      rd_data     <= addr_ok(rd_addr) ? active_q[rd_addr] : '0;
    end
  end

  // Banks: an update in the commit cycle copies the pre-commit shadow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(NREG); i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      if (upd_rise) begin
        for (int i = 0; i < int'(NREG); i++) active_q[i] <= shadow_q[i];
      end
      if (commit_q) begin
        shadow_q[addr_q] <= (nbytes(addr_q, SHORT_LAST) == 4'd4) ?
                            {32'h0, shift_in_q[31:0]} : shift_in_q;
      end
    end
  end

endmodule

// File: tb/tb_dds_spi_slave.sv
// Directed bench for dds_spi_slave: SPI master tasks, register-bank model and per-cycle output checks.
module tb_dds_spi_slave;

  localparam int NREG = 23;
  localparam int H    = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic        SCLK, CS, SDIO, IO_UPDATE;
  logic        SDO;
  logic [4:0]  rd_addr;
  logic [63:0] rd_data;
  logic        wr_strobe;
  logic [4:0]  wr_addr;
  logic        upd_pulse;

  dds_spi_slave dut (
    .clk(clk), .rst(rst), .SCLK(SCLK), .CS(CS), .SDIO(SDIO), .SDO(SDO),
    .IO_UPDATE(IO_UPDATE), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr), .upd_pulse(upd_pulse));

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0, wr_cnt = 0, upd_cnt = 0, wr_cyc = -1, upd_cyc = -2;
  int exp_wr = 0, exp_upd = 0;
  logic [4:0] last_wr_addr = '0;
  bit chk_en = 1'b0;
  logic [63:0] m_shadow [32];
  logic [63:0] m_active [32];
  logic [63:0] rd;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Register model: what the banks must hold after each completed transaction.
  task automatic m_reset();
    for (int i = 0; i < 32; i++) begin m_shadow[i] = '0; m_active[i] = '0; end
  endtask

  task automatic m_write(input int a, input logic [63:0] d);
    if (a < NREG) begin
      m_shadow[a] = (a <= 10) ? {32'h0, d[31:0]} : d;
      exp_wr++;
    end
  endtask

  task automatic m_update();
    for (int i = 0; i < 32; i++) m_active[i] = m_shadow[i];
    exp_upd++;
  endtask

  function automatic logic [63:0] exp_rd(input logic [4:0] a);
    return (int'(a) < NREG) ? m_active[a] : 64'h0;
  endfunction

  // Pulse counter for the strobe outputs.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (wr_strobe) begin wr_cnt++; last_wr_addr = wr_addr; wr_cyc = cyc; end
    if (upd_pulse) begin upd_cnt++; upd_cyc = cyc; end
  end

  // Compare process: in quiet windows every output must match the model.
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      chk("rd_data", rd_data, exp_rd(rd_addr));
      chk("wr_strobe_quiet", 64'(wr_strobe), 64'h0);
      chk("upd_pulse_quiet", 64'(upd_pulse), 64'h0);
      chk("sdo_quiet", 64'(SDO), 64'h0);
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic settle();
    wait_clk(8);
    chk_en = 1'b1;
    for (int a = 0; a < 32; a++) begin
      @(negedge clk);
      rd_addr = 5'(a);
    end
    @(negedge clk);
    chk_en = 1'b0;
  endtask

  task automatic peek(input string name, input logic [4:0] a, input logic [63:0] exp);
    @(negedge clk);
    rd_addr = a;
    @(posedge clk);
    #1;
    chk(name, rd_data, exp);
  endtask

  task automatic sclk_pulse(input logic b);
    SDIO = b;
    wait_clk(H);
    SCLK = 1'b1;
    wait_clk(H);
    SCLK = 1'b0;
  endtask

  // One master frame; SDO sampled just before each data rise. Optional IO_UPDATE one clk after the last rise.
  task automatic frame(input logic [7:0] instr, input logic [63:0] wdata, input int nsend,
                       input bit upd_at_end, output logic [63:0] rdata);
    int nb;
    nb = 8 + nsend;
    rdata = '0;
    @(negedge clk);
    CS = 1'b0;
    wait_clk(H);
    for (int i = 0; i < nb; i++) begin
      SDIO = (i < 8) ? instr[7-i] : wdata[nsend-1-(i-8)];
      wait_clk(H);
      if (i >= 8) rdata = {rdata[62:0], SDO};
      SCLK = 1'b1;
      if (upd_at_end && i == nb - 1) begin
        wait_clk(1);
        IO_UPDATE = 1'b1;
        wait_clk(H - 1);
      end else begin
        wait_clk(H);
      end
      SCLK = 1'b0;
    end
    wait_clk(H);
    CS   = 1'b1;
    SDIO = 1'b0;
    wait_clk(2 * H);
    IO_UPDATE = 1'b0;
    wait_clk(H);
  endtask

  task automatic io_update(input int hold);
    @(negedge clk);
    IO_UPDATE = 1'b1;
    wait_clk(hold);
    IO_UPDATE = 1'b0;
    wait_clk(8);
  endtask

  task automatic chk_counts(input string name);
    chk({name, "_wr_cnt"}, 64'(wr_cnt), 64'(exp_wr));
    chk({name, "_upd_cnt"}, 64'(upd_cnt), 64'(exp_upd));
  endtask

  initial begin
    rst = 1'b0; SCLK = 1'b0; CS = 1'b1; SDIO = 1'b0; IO_UPDATE = 1'b0; rd_addr = '0;
    m_reset();
    wait_clk(3);
    #1;
    chk("reset_sdo", 64'(SDO), 64'h0);
    chk("reset_rd_data", rd_data, 64'h0);
    chk("reset_wr_strobe", 64'(wr_strobe), 64'h0);
    chk("reset_wr_addr", 64'(wr_addr), 64'h0);
    chk("reset_upd_pulse", 64'(upd_pulse), 64'h0);
    @(negedge clk);
    rst = 1'b1;
    settle();

    // 32-bit write, visible on rd_data only after IO_UPDATE.
    frame(8'h01, 64'h0123_4567, 32, 1'b0, rd);
    m_write(1, 64'h0123_4567);
    chk_counts("wr01");
    chk("wr01_addr", 64'(last_wr_addr), 64'h1);
    peek("wr01_before_update", 5'd1, 64'h0);
    settle();
    io_update(8);
    m_update();
    chk_counts("upd01");
    peek("wr01_after_update", 5'd1, 64'h0000_0000_0123_4567);
    settle();

    // 64-bit write, level-held IO_UPDATE, read-back over SDO.
    frame(8'h0E, 64'h0FFF_0000_1234_5678, 64, 1'b0, rd);
    m_write(14, 64'h0FFF_0000_1234_5678);
    chk("wr0e_addr", 64'(last_wr_addr), 64'hE);
    io_update(30);
    m_update();
    chk_counts("upd0e_level");
    settle();
    frame(8'h8E, 64'h0, 64, 1'b0, rd);
    chk("rd8e_literal", rd, 64'h0FFF_0000_1234_5678);
    chk("rd8e_model", rd, m_active[14]);
    frame(8'h81, 64'h0, 32, 1'b0, rd);
    chk("rd81_literal", {32'h0, rd[31:0]}, 64'h0000_0000_0123_4567);
    chk_counts("reads");
    settle();

    // Aborted write, then a complete one to the same register.
    frame(8'h02, 64'hD_EADB, 20, 1'b0, rd);
    chk_counts("abort02");
    io_update(8);
    m_update();
    peek("abort02_active", 5'd2, 64'h0);
    settle();
    frame(8'h02, 64'hCAFE_F00D, 32, 1'b0, rd);
    m_write(2, 64'hCAFE_F00D);
    chk("wr02_addr", 64'(last_wr_addr), 64'h2);
    io_update(8);
    m_update();
    peek("wr02_active", 5'd2, 64'h0000_0000_CAFE_F00D);
    settle();

    // Commit and IO_UPDATE edge in the same cycle: active keeps the pre-commit value.
    frame(8'h03, 64'hAAAA_5555, 32, 1'b1, rd);
    m_update();
    m_write(3, 64'hAAAA_5555);
    chk_counts("sim03");
    chk("sim03_same_cycle", 64'(upd_cyc), 64'(wr_cyc));
    peek("sim03_active_old", 5'd3, 64'h0);
    settle();
    io_update(8);
    m_update();
    peek("sim03_active_new", 5'd3, 64'h0000_0000_AAAA_5555);
    settle();

    // Unimplemented address: 64 bits consumed, nothing stored, zeros read back.
    frame(8'h1F, 64'hFFFF_FFFF_FFFF_FFFF, 64, 1'b0, rd);
    chk_counts("wr1f");
    frame(8'h9F, 64'h0, 64, 1'b0, rd);
    chk("rd9f_zero", rd, 64'h0);
    settle();

    // Reset in the middle of a read; junk clocks with CS still low must not start a frame.
    @(negedge clk);
    CS = 1'b0;
    wait_clk(H);
    for (int i = 0; i < 8; i++) sclk_pulse(1'(8'h8E >> (7 - i)));
    for (int i = 0; i < 20; i++) sclk_pulse(1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_sdo", 64'(SDO), 64'h0);
    chk("midrst_rd_data", rd_data, 64'h0);
    chk("midrst_wr_strobe", 64'(wr_strobe), 64'h0);
    m_reset();
    wait_clk(3);
    rst = 1'b1;
    for (int i = 0; i < 12; i++) sclk_pulse(1'b1);
    chk("midrst_junk_sdo", 64'(SDO), 64'h0);
    wait_clk(H);
    CS = 1'b1;
    wait_clk(2 * H);
    chk("midrst_junk_wr", 64'(wr_cnt), 64'(exp_wr));
    settle();
    frame(8'h8E, 64'h0, 64, 1'b0, rd);
    chk("postrst_rd8e", rd, 64'h0);
    frame(8'h81, 64'h0, 32, 1'b0, rd);
    chk("postrst_rd81", rd, 64'h0);
    settle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
